ex_alu_buf3: RTL
================

Name: ex_alu_buf3

Overview:
- Execute stage directly downstream of the operand forwarding muxes.
- Consumes the forwarded op1/op2 data plus the decoded opcode, destination register and write-back enable. Performs the ALU operation and registers the result into the EX/WB pipeline buffer (buffer 3).
- The registered result and destination feed back to the forwarding unit and write-back.
- MUL is iterative and multi-cycle. It raises a stall so the upstream stages hold.

Parameters:
- WIDTH, 16, data width; also the MUL iteration count.
- ADDR_W, 4, register address width.
- OPC_W, 4, opcode width.

Ports:
- CLOCK  input  1  rising-edge clock.
- in_rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  instruction present at the stage input.
- in_opcode  input  OPC_W  ALU operation.
- in_op1_data  input  WIDTH  forwarded operand 1 (output of m2 mux).
- in_op2_data  input  WIDTH  forwarded operand 2 (output of mux3).
- in_dest  input  ADDR_W  destination register.
- in_wb_en  input  1  instruction writes the register file.
- out_alu_buf3  output  WIDTH  registered result.
- out_dest_buf3  output  ADDR_W  registered destination.
- out_wb_buf3  output  1  registered write-back enable.
- out_valid_buf3  output  1  buffer 3 holds a real instruction.
- out_zero_buf3  output  1  registered result == 0.
- out_carry_buf3  output  1  registered carry/borrow.
- out_stall  output  1  combinational; upstream must hold buffer 2 while high.

Behaviour:
- Reset (async, in_rst=1): all buf3 outputs 0, state IDLE, MUL counter 0, out_stall 0. A reset mid-MUL aborts the multiply, and no result is produced.
- Opcodes:
  - 0000 ADD; carry = bit WIDTH of op1+op2.
  - 0001 SUB = op1-op2; carry = borrow (1 iff op1<op2 unsigned).
  - 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL by op2[3:0]; 0110 SRL (logical) by op2[3:0].
  - 0111 MUL: low WIDTH bits of the unsigned product.
  - 1000 PASS op2.
  - 1001-1111 NOP: out_valid_buf3=1, out_wb_buf3 forced 0, result 0.
- Carry is 0 for every op except ADD/SUB. Zero flag is computed on the registered result.
- States are IDLE and BUSY.
- IDLE, in_valid=0: next edge loads a bubble (valid=0, wb=0, result/dest/flags 0).
- IDLE, in_valid=1, non-MUL: next edge loads result, dest, wb, flags, valid=1. Latency is 1 cycle and out_stall stays 0.
- IDLE, in_valid=1, MUL:
  - out_stall=1 in the accept cycle.
  - The edge captures the operands into the multiplicand/multiplier/accumulator registers, sets counter=0 and goes to BUSY.
  - It also loads a bubble into buf3.
- BUSY: one shift-add step per edge; counter increments.
  - out_stall = (counter != WIDTH-1).
  - Inputs are ignored in BUSY; upstream still presents the held MUL.
  - On the edge with counter==WIDTH-1: buf3 loads the product, dest, wb, flags (carry 0), valid=1, and state returns to IDLE.
  - In that final cycle stall=0, so upstream advances on the same edge.
  - A MUL therefore occupies the input for WIDTH+1 cycles. The result appears WIDTH+1 edges after the accept cycle begins.
- buf3 holds a bubble during BUSY. The forwarding unit sees wb=0 and selects no forward from buf3.
- Back-to-back MULs: the second MUL is accepted in the IDLE cycle immediately after completion.

Optional Feature:
- Macro EX_MUL_FAST_EN.
- Defined: MUL is a single-cycle combinational multiply with the same timing as other ops. The BUSY state is never entered and out_stall is tied 0.
- Undefined: iterative multiply as described above.

Test Plan:
- ADD op1=0x7FFF op2=0x0001, then ADD 0xFFFF+0x0001 -> buf3 results 0x8000 (zero 0, carry 0) and 0x0000 (zero 1, carry 1), each 1 edge after presentation; out_stall stays 0.
- SUB op1=0x0003 op2=0x0005 dest=4 wb=1 -> out_alu_buf3=0xFFFE, carry 1, dest 4, wb 1.
- SLL op1=0x0001 op2=0x0013 -> 0x0008 (only op2[3:0] is used). SRL op1=0x8000 op2=0x000F -> 0x0001.
- MUL op1=0x0012 op2=0x0034 -> out_stall high for 16 cycles, then low. buf3 valid=0 until the 17th edge, which loads 0x03A8. With EX_MUL_FAST_EN, 0x03A8 after 1 edge and no stall.
- MUL 0x0100*0x0100 -> 0x0000 with zero=1. Then an immediate ADD 0x0002+0x0003 -> 0x0005 on the following edge.
- Reset asserted at BUSY counter=5 -> all outputs 0 immediately, out_stall 0. After release, IDLE with in_valid=0 yields bubbles only.

Source files
------------

// File: rtl/ex_alu_buf3.sv
// Execute stage: ALU plus EX/WB pipeline buffer 3, iterative shift-add MUL.
// Optional macro EX_MUL_FAST_EN selects a single-cycle combinational MUL.
module ex_alu_buf3 #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4,
    parameter int OPC_W  = 4
) (
    input  logic              CLOCK,
    input  logic              in_rst,
    input  logic              in_valid,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [WIDTH-1:0]  in_op1_data,
    input  logic [WIDTH-1:0]  in_op2_data,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_wb_en,
    output logic [WIDTH-1:0]  out_alu_buf3,
    output logic [ADDR_W-1:0] out_dest_buf3,
    output logic              out_wb_buf3,
    output logic              out_valid_buf3,
    output logic              out_zero_buf3,
    output logic              out_carry_buf3,
    output logic              out_stall
);

    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_SLL  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SRL  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_PASS = OPC_W'(8);

    logic [WIDTH-1:0]  r_alu;
    logic [ADDR_W-1:0] r_dest;
    logic              r_wb;
    logic              r_valid;
    logic              r_zero;
    logic              r_carry;

    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_diff;
    logic [WIDTH-1:0]  w_mul;
    logic [WIDTH-1:0]  w_res;
    logic              w_carry;
    logic              w_wb;
    logic              w_is_mul;

    assign w_sum    = {1'b0, in_op1_data} + {1'b0, in_op2_data};
    assign w_diff   = {1'b0, in_op1_data} - {1'b0, in_op2_data};
    assign w_is_mul = (in_opcode == OP_MUL);

`ifdef EX_MUL_FAST_EN
    assign w_mul = in_op1_data * in_op2_data;
`else
    assign w_mul = '0;
`endif

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_wb    = in_wb_en;
        case (in_opcode)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            OP_AND:  w_res = in_op1_data & in_op2_data;
            OP_OR:   w_res = in_op1_data | in_op2_data;
            OP_XOR:  w_res = in_op1_data ^ in_op2_data;
            OP_SLL:  w_res = in_op1_data << in_op2_data[3:0];
            OP_SRL:  w_res = in_op1_data >> in_op2_data[3:0];
            OP_MUL:  w_res = w_mul;
            OP_PASS: w_res = in_op2_data;
            default: w_wb  = 1'b0;
        endcase
    end

`ifdef EX_MUL_FAST_EN
    always_ff @(posedge CLOCK or posedge in_rst) begin
        if (in_rst) begin
            r_alu   <= '0;
            r_dest  <= '0;
            r_wb    <= 1'b0;
            r_valid <= 1'b0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (in_valid) begin
            r_alu   <= w_res;
            r_dest  <= in_dest;
            r_wb    <= w_wb;
            r_valid <= 1'b1;
            r_zero  <= (w_res == '0);
            r_carry <= w_carry;
        end else begin
            r_alu   <= '0;
            r_dest  <= '0;
            r_wb    <= 1'b0;
            r_valid <= 1'b0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end
    end

    assign out_stall = 1'b0;
    logic w_unused;
    assign w_unused = w_is_mul;
`else
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_step;

    // Accumulator after adding this step's partial product.
    assign w_step = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge CLOCK or posedge in_rst) begin
        if (in_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_alu    <= '0;
            r_dest   <= '0;
            r_wb     <= 1'b0;
            r_valid  <= 1'b0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            r_alu   <= '0;
            r_dest  <= '0;
            r_wb    <= 1'b0;
            r_valid <= 1'b0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid && w_is_mul) begin
                        r_mcand  <= in_op1_data;
                        r_mplier <= in_op2_data;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= BUSY;
                    end else if (in_valid) begin
                        r_alu   <= w_res;
                        r_dest  <= in_dest;
                        r_wb    <= w_wb;
                        r_valid <= 1'b1;
                        r_zero  <= (w_res == '0);
                        r_carry <= w_carry;
                    end
                end
                BUSY: begin
                    r_acc    <= w_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_alu   <= w_step;
                        r_dest  <= in_dest;
                        r_wb    <= in_wb_en;
                        r_valid <= 1'b1;
                        r_zero  <= (w_step == '0);
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Held low during reset even if a MUL is still presented upstream.
    assign out_stall = !in_rst &&
        (((r_state == IDLE) && in_valid && w_is_mul) ||
         ((r_state == BUSY) && (r_cnt != LAST)));
`endif

    assign out_alu_buf3   = r_alu;
    assign out_dest_buf3  = r_dest;
    assign out_wb_buf3    = r_wb;
    assign out_valid_buf3 = r_valid;
    assign out_zero_buf3  = r_zero;
    assign out_carry_buf3 = r_carry;

endmodule
